// File: rtl/motor_ramp_ctrl.sv
// Duty ramp and direction-reversal sequencer for one motor channel.
// Optional build macro MOTOR_RAMP_BYPASS_EN: apply targets in full on each frame tick.
module motor_ramp_ctrl #(
    parameter logic [9:0] STEP        = 10'd8,
    parameter int         DEAD_FRAMES = 4,
    parameter logic [9:0] MIN_DUTY    = 10'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_vld,
    input  logic [9:0] cmd_duty,
    input  logic       cmd_dir,
    output logic       cmd_rdy,
    output logic [9:0] duty,
    output logic       fwd,
    output logic       rev,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RAMP, DOWN, DEAD} state_t;

    state_t     state_q, state_d;
    logic [9:0] frameCnt_q, frameCnt_d;
    logic [9:0] tgtDuty_q, tgtDuty_d;
    logic       tgtDir_q, tgtDir_d;
    logic       curDir_q, curDir_d;
    logic [9:0] duty_q, duty_d;
    logic [3:0] deadCnt_q, deadCnt_d;
    logic       fwd_q, rev_q, cmdRdy_q, busy_q;

    logic       frameTick;
    logic       accept;
    logic [9:0] cmdClamped;
    logic [9:0] stepToTgt;
    logic [9:0] stepToMin;

`ifdef MOTOR_RAMP_BYPASS_EN
    function automatic logic [9:0] rampStep(input logic [9:0] cur, input logic [9:0] tgt);
        logic [9:0] unusedCur;
        unusedCur = cur;
        rampStep  = tgt;
    endfunction
`else
    // The 11-bit difference keeps the "within one step" test free of wraparound.
    function automatic logic [9:0] rampStep(input logic [9:0] cur, input logic [9:0] tgt);
        logic [10:0] diff;
        if (tgt >= cur) begin
            diff     = {1'b0, tgt} - {1'b0, cur};
            rampStep = (diff <= {1'b0, STEP}) ? tgt : cur + STEP;
        end else begin
            diff     = {1'b0, cur} - {1'b0, tgt};
            rampStep = (diff <= {1'b0, STEP}) ? tgt : cur - STEP;
        end
    endfunction
`endif

    always_comb begin
        frameTick  = &frameCnt_q;
        accept     = cmd_vld & cmdRdy_q;
        cmdClamped = (cmd_duty < MIN_DUTY) ? MIN_DUTY : cmd_duty;
        stepToTgt  = rampStep(duty_q, tgtDuty_q);
        stepToMin  = rampStep(duty_q, MIN_DUTY);

        state_d    = state_q;
        frameCnt_d = frameCnt_q + 10'd1;
        tgtDuty_d  = tgtDuty_q;
        tgtDir_d   = tgtDir_q;
        curDir_d   = curDir_q;
        duty_d     = duty_q;
        deadCnt_d  = deadCnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgtDuty_d = cmdClamped;
                    tgtDir_d  = cmd_dir;
                    if (cmd_dir != curDir_q)
                        state_d = DOWN;
                    else if (cmdClamped != duty_q)
                        state_d = RAMP;
                end
            end
            RAMP: begin
                // A tick in the acceptance cycle still steps toward the old target.
                if (frameTick) begin
                    duty_d = stepToTgt;
                    if (stepToTgt == tgtDuty_q)
                        state_d = IDLE;
                end
                if (accept) begin
                    tgtDuty_d = cmdClamped;
                    tgtDir_d  = cmd_dir;
                    state_d   = (cmd_dir != curDir_q) ? DOWN : RAMP;
                end
            end
            DOWN: begin
                if (frameTick) begin
                    duty_d = stepToMin;
                    if (stepToMin == MIN_DUTY) begin
                        state_d   = DEAD;
                        deadCnt_d = 4'(DEAD_FRAMES);
                    end
                end
            end
            DEAD: begin
                duty_d = MIN_DUTY;
                if (frameTick) begin
                    deadCnt_d = deadCnt_q - 4'd1;
                    if (deadCnt_q == 4'd1) begin
                        curDir_d = tgtDir_q;
                        state_d  = (tgtDuty_q == MIN_DUTY) ? IDLE : RAMP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they move with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frameCnt_q <= '0;
            tgtDuty_q  <= MIN_DUTY;
            tgtDir_q   <= 1'b1;
            curDir_q   <= 1'b1;
            duty_q     <= MIN_DUTY;
            deadCnt_q  <= '0;
            fwd_q      <= 1'b1;
            rev_q      <= 1'b0;
            cmdRdy_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frameCnt_q <= frameCnt_d;
            tgtDuty_q  <= tgtDuty_d;
            tgtDir_q   <= tgtDir_d;
            curDir_q   <= curDir_d;
            duty_q     <= duty_d;
            deadCnt_q  <= deadCnt_d;
            fwd_q      <= (state_d != DEAD) &  curDir_d;
            rev_q      <= (state_d != DEAD) & ~curDir_d;
            cmdRdy_q   <= (state_d == IDLE) || (state_d == RAMP);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign duty    = duty_q;
    assign fwd     = fwd_q;
    assign rev     = rev_q;
    assign cmd_rdy = cmdRdy_q;
    assign busy    = busy_q;

endmodule
